// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: LM/SM opcodes,
// FSM state encoding, field widths and an opcode decode helper.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned IR_W   = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned MASK_W = 8;
  localparam int unsigned OFF_W  = 3;

  localparam logic [OP_W-1:0] OP_LM = 4'b0110;
  localparam logic [OP_W-1:0] OP_SM = 4'b0111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

  // True for the two multiple-transfer opcodes.
  function automatic logic is_multi_op(input logic [OP_W-1:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives decode/execute status, receives controls
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  // decode / execute status
  logic [IR_W-1:0]  id_ir;
  logic             id_valid;
  logic [REG_W-1:0] id_rA1;
  logic [REG_W-1:0] id_rA2;
  logic             id_use1;
  logic             id_use2;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_dest;
  logic             br_taken;

  // pipeline controls and micro-op sequence
  logic             stall_pc;
  logic             stall_if_id;
  logic             flush_if_id;
  logic             flush_id_rr;
  logic             bubble_rr_ex;
  logic             ms_active;
  logic [REG_W-1:0] ms_reg;
  logic [OFF_W-1:0] ms_offset;
  logic             ms_first;
  logic             ms_last;

  modport master (
    output id_ir, id_valid, id_rA1, id_rA2, id_use1, id_use2,
           ex_mem_read, ex_dest, br_taken,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_rr, bubble_rr_ex,
           ms_active, ms_reg, ms_offset, ms_first, ms_last
  );

  modport slave (
    input  id_ir, id_valid, id_rA1, id_rA2, id_use1, id_use2,
           ex_mem_read, ex_dest, br_taken,
    output stall_pc, stall_if_id, flush_if_id, flush_id_rr, bubble_rr_ex,
           ms_active, ms_reg, ms_offset, ms_first, ms_last
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_lsb_encode8.sv
// Lowest-set-bit priority encoder.
//   in_vec    : 8-bit vector
//   idx_c     : index of the lowest set bit (0 when in_vec is zero)
//   one_hot_c : in_vec has exactly one bit set
module lsb_encode8
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [MASK_W-1:0] in_vec,
  output logic [REG_W-1:0]  idx_c,
  output logic              one_hot_c
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx_c = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (in_vec[i]) idx_c = REG_W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign one_hot_c = (in_vec != '0) && ((in_vec & (in_vec - MASK_W'(1))) == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// LM/SM micro-op sequencing (one register transfer per cycle).
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   hz    : slave side of pipeline_hazard_ctrl_if; all controls are
//           combinational from current state and decode/execute status
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  state_e            state_q, state_d;
  logic [MASK_W-1:0] mask_q,  mask_d;
  logic [OFF_W-1:0]  offset_q, offset_d;

  logic [REG_W-1:0]  lsb_idx;
  logic              lsb_one_hot;
  logic              load_use;
  logic              ms_entry;

  logic              stall_pc, stall_if_id, flush_if_id, flush_id_rr;
  logic              bubble_rr_ex, ms_active, ms_first, ms_last;
  logic [REG_W-1:0]  ms_reg;
  logic [OFF_W-1:0]  ms_offset;

  lsb_encode8 u_lsb (
    .in_vec    (mask_q),
    .idx_c     (lsb_idx),
    .one_hot_c (lsb_one_hot)
  );

  // Decode-stage source matches an in-flight load's destination.
  assign load_use = hz.id_valid && hz.ex_mem_read &&
                    ((hz.id_use1 && (hz.id_rA1 == hz.ex_dest)) ||
                     (hz.id_use2 && (hz.id_rA2 == hz.ex_dest)));

  // LM/SM with an empty list never enters the sequencer.
  assign ms_entry = hz.id_valid && is_multi_op(hz.id_ir[15:12]) &&
                    (hz.id_ir[7:0] != '0);

  // State, mask and offset registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      offset_q <= offset_d;
    end
  end

  // Next state and controls; a taken branch outranks everything.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    offset_d     = offset_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_rr  = 1'b0;
    bubble_rr_ex = 1'b0;
    ms_active    = 1'b0;
    ms_reg       = '0;
    ms_offset    = '0;
    ms_first     = 1'b0;
    ms_last      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hz.br_taken) begin
          flush_if_id = 1'b1;
          flush_id_rr = 1'b1;
        end else if (load_use) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_rr_ex = 1'b1;
        end else if (ms_entry) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_rr_ex = 1'b1;
          mask_d       = hz.id_ir[7:0];
          offset_d     = '0;
          state_d      = ST_MULTI;
        end
      end

      ST_MULTI: begin
        if (hz.br_taken) begin
          // An older branch kills the whole sequence.
          flush_if_id = 1'b1;
          flush_id_rr = 1'b1;
          state_d     = ST_IDLE;
          mask_d      = '0;
          offset_d    = '0;
        end else begin
          ms_active   = 1'b1;
          ms_reg      = lsb_idx;
          ms_offset   = offset_q;
          ms_first    = (offset_q == '0);
          ms_last     = lsb_one_hot;
          // Release decode on the last issue so the next instruction moves up.
          stall_pc    = !lsb_one_hot;
          stall_if_id = !lsb_one_hot;
          if (lsb_one_hot) begin
            state_d  = ST_IDLE;
            mask_d   = '0;
            offset_d = '0;
          end else begin
            mask_d   = mask_q & ~(MASK_W'(1) << lsb_idx);
            offset_d = offset_q + OFF_W'(1);
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mask_d   = '0;
        offset_d = '0;
      end
    endcase
  end

  assign hz.stall_pc     = stall_pc;
  assign hz.stall_if_id  = stall_if_id;
  assign hz.flush_if_id  = flush_if_id;
  assign hz.flush_id_rr  = flush_id_rr;
  assign hz.bubble_rr_ex = bubble_rr_ex;
  assign hz.ms_active    = ms_active;
  assign hz.ms_reg       = ms_reg;
  assign hz.ms_offset    = ms_offset;
  assign hz.ms_first     = ms_first;
  assign hz.ms_last      = ms_last;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver applies one cycle of
// inputs, predicts the response from a register-list reference model and
// queues it; a monitor pops and compares at the falling edge.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz_if ();

  pipeline_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  // {stall_pc, stall_if_id, flush_if_id, flush_id_rr, bubble_rr_ex,
  //  ms_active, ms_reg[2:0], ms_offset[2:0], ms_first, ms_last}
  typedef struct {
    logic [13:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the outstanding register list of the current LM/SM.
  bit   m_multi  = 1'b0;
  int   m_pend[$];
  int   m_issued = 0;

  function automatic logic [13:0] pack_out(bit s_pc, bit s_ifid, bit f_ifid,
                                           bit f_idrr, bit bub, bit act,
                                           int r, int off, bit first, bit last);
    return {s_pc, s_ifid, f_ifid, f_idrr, bub, act, 3'(r), 3'(off), first, last};
  endfunction

  task automatic step(input bit rst, input logic [15:0] ir, input bit valid,
                      input logic [2:0] ra1, input logic [2:0] ra2,
                      input bit u1, input bit u2, input bit mr,
                      input logic [2:0] dst, input bit br, input string tag,
                      output logic [13:0] e);
    bit   lu;
    bit   last;
    int   r;
    exp_t x;
    @(posedge clk);
    #1;
    reset             = rst;
    hz_if.id_ir       = ir;
    hz_if.id_valid    = valid;
    hz_if.id_rA1      = ra1;
    hz_if.id_rA2      = ra2;
    hz_if.id_use1     = u1;
    hz_if.id_use2     = u2;
    hz_if.ex_mem_read = mr;
    hz_if.ex_dest     = dst;
    hz_if.br_taken    = br;
    e = '0;
    if (!rst) begin
      m_multi = 1'b0;
      m_pend.delete();
      m_issued = 0;
      return;
    end
    lu = valid && mr && ((u1 && ra1 == dst) || (u2 && ra2 == dst));
    if (m_multi) begin
      if (br) begin
        e = pack_out(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        m_pend.delete();
        m_multi  = 1'b0;
        m_issued = 0;
      end else begin
        r    = m_pend.pop_front();
        last = (m_pend.size() == 0);
        e    = pack_out(!last, !last, 0, 0, 0, 1, r, m_issued, m_issued == 0, last);
        m_issued++;
        if (last) m_multi = 1'b0;
      end
    end else if (br) begin
      e = pack_out(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    end else if (lu) begin
      e = pack_out(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    end else if (valid && (ir[15:12] == 4'h6 || ir[15:12] == 4'h7) && ir[7:0] != 8'h00) begin
      e = pack_out(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      for (int b = 0; b < 8; b++) if (ir[b]) m_pend.push_back(b);
      m_multi  = 1'b1;
      m_issued = 0;
    end
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    exp_t        x;
    logic [13:0] got;
    if (sb.size() > 0) begin
      x   = sb.pop_front();
      got = {hz_if.stall_pc, hz_if.stall_if_id, hz_if.flush_if_id,
             hz_if.flush_id_rr, hz_if.bubble_rr_ex, hz_if.ms_active,
             hz_if.ms_reg, hz_if.ms_offset, hz_if.ms_first, hz_if.ms_last};
      n_cmp++;
      if (got !== x.exp) begin
        n_bad++;
        $display("FAIL %s @%0t: got %b expected %b", x.tag, $time, got, x.exp);
      end
    end
  end

  initial begin
    logic [13:0] e;
    logic [15:0] cur_ir;
    bit          cur_valid, cur_u1, cur_u2, br, mr, rst;
    logic [2:0]  cur_ra1, cur_ra2, dst;
    int          k;

    hz_if.id_ir = '0; hz_if.id_valid = 1'b0; hz_if.id_rA1 = '0; hz_if.id_rA2 = '0;
    hz_if.id_use1 = 1'b0; hz_if.id_use2 = 1'b0; hz_if.ex_mem_read = 1'b0;
    hz_if.ex_dest = '0; hz_if.br_taken = 1'b0;

    // reset, then an idle cycle must be all zero
    step(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "rst", e);
    step(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "rst", e);
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "after_reset", e);

    // load-use: one stall cycle, gone once the load has moved on
    step(1, 16'h0123, 1, 3, 5, 1, 0, 1, 3, 0, "load_use", e);
    step(1, 16'h0123, 1, 3, 5, 1, 0, 0, 3, 0, "load_use_clear", e);
    step(1, 16'h0123, 1, 1, 3, 0, 1, 1, 3, 0, "load_use_src2", e);
    step(1, 16'h0123, 1, 3, 5, 0, 0, 1, 3, 0, "no_use_no_stall", e);

    // LM 0xA5: entry then regs 0,2,5,7
    for (int i = 0; i < 5; i++) step(1, 16'h60A5, 1, 0, 0, 0, 0, 0, 0, 0, "lm_a5", e);
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "lm_a5_done", e);

    // empty-list SM passes through
    step(1, 16'h7000, 1, 0, 0, 0, 0, 0, 0, 0, "sm_empty", e);
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "sm_empty_done", e);

    // abort on the second issue cycle of LM 0xFF
    step(1, 16'h60FF, 1, 0, 0, 0, 0, 0, 0, 0, "abort_entry", e);
    step(1, 16'h60FF, 1, 0, 0, 0, 0, 0, 0, 0, "abort_issue1", e);
    step(1, 16'h60FF, 1, 0, 0, 0, 0, 0, 0, 1, "abort_flush", e);
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "abort_idle", e);

    // reset with mask 0xF0 loaded
    step(1, 16'h70F0, 1, 0, 0, 0, 0, 0, 0, 0, "rst_mid_entry", e);
    step(0, 16'h70F0, 1, 0, 0, 0, 0, 0, 0, 0, "rst_mid", e);
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid_after", e);

    // branch beats load-use
    step(1, 16'h0123, 1, 3, 5, 1, 0, 1, 3, 1, "prio_flush", e);

    // load-use on the LM base delays entry by one cycle
    step(1, 16'h6A81, 1, 5, 0, 1, 0, 1, 5, 0, "lm_base_hazard", e);
    for (int i = 0; i < 3; i++) step(1, 16'h6A81, 1, 5, 0, 1, 0, 0, 5, 0, "lm_base_seq", e);
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "lm_base_done", e);

    // randomized traffic; decode holds its instruction while stalled
    cur_ir = '0; cur_valid = 0; cur_ra1 = 0; cur_ra2 = 0; cur_u1 = 0; cur_u2 = 0;
    e = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!e[12]) begin
        k = int'($urandom_range(0, 99));
        cur_ir = 16'($urandom);
        if (k < 25)      cur_ir[15:12] = 4'h6;
        else if (k < 40) cur_ir[15:12] = 4'h7;
        if ($urandom_range(0, 9) == 0) cur_ir[7:0] = 8'h00;
        cur_valid = ($urandom_range(0, 9) != 0);
        cur_ra1 = 3'($urandom);
        cur_ra2 = 3'($urandom);
        cur_u1  = 1'($urandom);
        cur_u2  = 1'($urandom);
      end
      mr  = ($urandom_range(0, 9) < 4);
      dst = ($urandom_range(0, 1) == 0) ? cur_ra1 : 3'($urandom);
      br  = ($urandom_range(0, 99) < 8);
      rst = ($urandom_range(0, 99) != 0);
      step(rst, cur_ir, cur_valid, cur_ra1, cur_ra2, cur_u1, cur_u2, mr, dst, br, "random", e);
    end

    step(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "drain", e);
    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
